mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter and burst sequencer sharing the single main-memory port between the instruction-cache refill path (IF stage, raised on `Imiss`) and the data-cache refill/write-back path (MA stage, raised on a D-cache miss). It sits below both caches, grants one requester at a time, and runs a full-line burst of single-word memory transactions. Each requester stays stalled through the hazard unit until this block returns its done pulse.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, word width; one memory transaction moves one word
- `LINE_WORDS`, 4, words per cache line; power of two, 2..16

Ports (one clock; reset is synchronous and active-high):
- `Clk`  in  1  clock, all state on the rising edge
- `Rst`  in  1  synchronous active-high reset
- `i_ic_req`  in  1  I-cache line-refill request, level
- `i_ic_addr`  in  ADDR_W  I-cache miss address
- `o_ic_gnt`  out  1  I-cache owns the port (XFER and DONE)
- `o_ic_rvalid`  out  1  `o_rdata` carries I-cache word `o_word`
- `o_ic_done`  out  1  one-cycle pulse, I-cache line complete
- `i_dc_req`  in  1  D-cache request, level
- `i_dc_we`  in  1  1 = line write-back, 0 = line refill
- `i_dc_addr`  in  ADDR_W  D-cache line address
- `i_dc_wdata`  in  DATA_W  write word selected by `o_word`; combinational from the D-cache
- `o_dc_gnt`  out  1  D-cache owns the port
- `o_dc_rvalid`  out  1  `o_rdata` carries D-cache refill word `o_word`
- `o_dc_done`  out  1  one-cycle pulse, D-cache line complete
- `o_rdata`  out  DATA_W  registered read word, shared
- `o_word`  out  log2(LINE_WORDS)  current word index; registered with `o_rdata` when rvalid is high
- `o_mem_req`  out  1  memory request, held until acked
- `o_mem_we`  out  1  memory write
- `o_mem_addr`  out  ADDR_W  word byte address
- `o_mem_wdata`  out  DATA_W  equals `i_dc_wdata` during a write-back
- `i_mem_ack`  in  1  one word accepted or returned this cycle
- `i_mem_rdata`  in  DATA_W  read data, valid with `i_mem_ack`

## Operation
- States are IDLE, XFER and DONE. A flag `last_i` records the last requester served; it resets to 1, so the D-cache wins the first tie.
- IDLE:
  - If only one request is high, grant that requester.
  - If both are high, grant D when `last_i`=1, otherwise grant I.
  - On grant, latch `base = addr` with its low log2(LINE_WORDS)+2 bits cleared. Latch the owner, and latch `we` (always 0 for I). Clear the word counter `k`, update `last_i`, then go to XFER.
- XFER:
  - `o_mem_req`=1, `o_mem_addr = base + 4*k`. The offset never carries into the line-base bits.
  - A request is held stable until `i_mem_ack` arrives.
  - On each ack, `k` increments. On a read ack, `i_mem_rdata` and `k` register into `o_rdata`/`o_word`, and the owner's rvalid pulses on the next cycle.
  - A write ack advances `o_word` to select the next `i_dc_wdata`.
  - The ack for `k = LINE_WORDS-1` moves the FSM to DONE.
- DONE: `o_mem_req`=0, the owner's gnt stays 1, and the owner's done=1 for exactly one cycle. The FSM then returns to IDLE. Requests are ignored during DONE.
- Requester rule: deassert req on the edge that samples done=1. Any req seen high in IDLE is a new line request.
- Request or address changes while in XFER or DONE are ignored; all transaction parameters are latched at grant.
- `i_mem_ack` outside XFER is ignored.
- At most one gnt, rvalid or done is high in any cycle.
- `Rst`:
  - Forces IDLE, `k`=0, `last_i`=1, and all outputs 0, including `o_rdata` and `o_word`.
  - Reset during XFER abandons the burst with no done pulse; the memory must discard the outstanding request.
  - Reset has priority over every other event.

## Timing
- Request high in cycle 0 (IDLE): gnt and `o_mem_req` go high in cycle 1.
- With a zero-wait memory (ack in every XFER cycle):
  - words are transferred in cycles 1..LINE_WORDS;
  - read rvalid is high in cycles 2..LINE_WORDS+1;
  - done is high in cycle LINE_WORDS+1, together with the last rvalid;
  - IDLE is in cycle LINE_WORDS+2;
  - the earliest next grant is cycle LINE_WORDS+3.
- Wait states stretch XFER one cycle per cycle without an ack; nothing else changes.
- Output timing: `o_mem_wdata` is combinational from `i_dc_wdata`. All other outputs are registered.

## Test plan
- I-only refill, LINE_WORDS=4, `i_ic_addr`=0x1234, zero-wait memory:
  - `o_mem_addr` = 0x1230, 0x1234, 0x1238, 0x123C in cycles 1-4;
  - `o_ic_rvalid` in cycles 2-5 with `o_word` 0..3;
  - `o_ic_done` in cycle 5 only.
- Both requesting in cycle 0 straight after reset: D is served first. I is granted in cycle 7 and D waits. If D re-requests during I's burst, it wins next (alternation).
- D write-back to 0x80, memory acking every 3rd cycle:
  - `o_mem_we`=1, and addr/wdata are held stable between acks;
  - `o_word` steps 0..3 and `o_mem_wdata` tracks `i_dc_wdata`;
  - done comes one cycle after the 4th ack;
  - `o_dc_rvalid` never rises.
- `i_ic_addr` changed and `i_dc_req` raised mid-burst: the address sequence is unchanged and there is no grant switch before DONE.
- `Rst` asserted after the second ack of a burst: next cycle all outputs are 0 and there is no done pulse. After release, the same pending request restarts at word 0.
- Spurious `i_mem_ack` in IDLE and DONE: no rvalid, no counter change.

Source files
------------

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter: round-robin I/D cache arbiter with single-word line bursts
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4,
   localparam int WORD_W    = $clog2(LINE_WORDS)
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              i_ic_req,
   input  logic [ADDR_W-1:0] i_ic_addr,
   output logic              o_ic_gnt,
   output logic              o_ic_rvalid,
   output logic              o_ic_done,
   input  logic              i_dc_req,
   input  logic              i_dc_we,
   input  logic [ADDR_W-1:0] i_dc_addr,
   input  logic [DATA_W-1:0] i_dc_wdata,
   output logic              o_dc_gnt,
   output logic              o_dc_rvalid,
   output logic              o_dc_done,
   output logic [DATA_W-1:0] o_rdata,
   output logic [WORD_W-1:0] o_word,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic              i_mem_ack,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam int                OFF_W    = WORD_W + 2;
   localparam logic [ADDR_W-1:0] C_OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
   localparam logic [WORD_W-1:0] C_LAST   = WORD_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                owner_dc_q, owner_dc_d;
   logic                we_q, we_d;
   logic                last_i_q, last_i_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [WORD_W-1:0]   k_q, k_d;
   logic                ic_gnt_q, ic_gnt_d;
   logic                dc_gnt_q, dc_gnt_d;
   logic                ic_rvalid_q, ic_rvalid_d;
   logic                dc_rvalid_q, dc_rvalid_d;
   logic                ic_done_q, ic_done_d;
   logic                dc_done_q, dc_done_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

   logic                pick_dc;
   logic [ADDR_W-1:0]   grant_base;
   logic [WORD_W-1:0]   k_inc;

   always_comb begin
      state_d     = state_q;
      owner_dc_d  = owner_dc_q;
      we_d        = we_q;
      last_i_d    = last_i_q;
      base_d      = base_q;
      k_d         = k_q;
      ic_gnt_d    = ic_gnt_q;
      dc_gnt_d    = dc_gnt_q;
      ic_rvalid_d = 1'b0;
      dc_rvalid_d = 1'b0;
      ic_done_d   = 1'b0;
      dc_done_d   = 1'b0;
      rdata_d     = rdata_q;
      word_d      = word_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;

      // D wins a tie only when I was served last
      pick_dc    = i_dc_req && (!i_ic_req || last_i_q);
      grant_base = (pick_dc ? i_dc_addr : i_ic_addr) & ~C_OFF_MASK;
      k_inc      = k_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            ic_gnt_d  = 1'b0;
            dc_gnt_d  = 1'b0;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            if (i_ic_req || i_dc_req) begin
               state_d    = S_XFER;
               owner_dc_d = pick_dc;
               we_d       = pick_dc & i_dc_we;
               last_i_d   = !pick_dc;
               base_d     = grant_base;
               k_d        = '0;
               word_d     = '0;
               ic_gnt_d   = !pick_dc;
               dc_gnt_d   = pick_dc;
               mem_req_d  = 1'b1;
               mem_we_d   = pick_dc & i_dc_we;
               mem_addr_d = grant_base;
            end
         end
         S_XFER: begin
            if (i_mem_ack) begin
               k_d = k_inc;
               if (we_q) begin
                  word_d = k_inc;
               end else begin
                  rdata_d     = i_mem_rdata;
                  word_d      = k_q;
                  ic_rvalid_d = !owner_dc_q;
                  dc_rvalid_d = owner_dc_q;
               end
               if (k_q == C_LAST) begin
                  state_d   = S_DONE;
                  mem_req_d = 1'b0;
                  mem_we_d  = 1'b0;
                  ic_done_d = !owner_dc_q;
                  dc_done_d = owner_dc_q;
               end else begin
                  // offset lives entirely in the cleared low bits, so no carry
                  mem_addr_d = base_q | ADDR_W'({k_inc, 2'b00});
               end
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            k_d      = '0;
            ic_gnt_d = 1'b0;
            dc_gnt_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= S_IDLE;
         owner_dc_q  <= 1'b0;
         we_q        <= 1'b0;
         last_i_q    <= 1'b1;
         base_q      <= '0;
         k_q         <= '0;
         ic_gnt_q    <= 1'b0;
         dc_gnt_q    <= 1'b0;
         ic_rvalid_q <= 1'b0;
         dc_rvalid_q <= 1'b0;
         ic_done_q   <= 1'b0;
         dc_done_q   <= 1'b0;
         rdata_q     <= '0;
         word_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_dc_q  <= owner_dc_d;
         we_q        <= we_d;
         last_i_q    <= last_i_d;
         base_q      <= base_d;
         k_q         <= k_d;
         ic_gnt_q    <= ic_gnt_d;
         dc_gnt_q    <= dc_gnt_d;
         ic_rvalid_q <= ic_rvalid_d;
         dc_rvalid_q <= dc_rvalid_d;
         ic_done_q   <= ic_done_d;
         dc_done_q   <= dc_done_d;
         rdata_q     <= rdata_d;
         word_q      <= word_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
      end
   end

   assign o_ic_gnt    = ic_gnt_q;
   assign o_dc_gnt    = dc_gnt_q;
   assign o_ic_rvalid = ic_rvalid_q;
   assign o_dc_rvalid = dc_rvalid_q;
   assign o_ic_done   = ic_done_q;
   assign o_dc_done   = dc_done_q;
   assign o_rdata     = rdata_q;
   assign o_word      = word_q;
   assign o_mem_req   = mem_req_q;
   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_we_q ? i_dc_wdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ic_req, dc_req, dc_we, mem_ack;
   logic [31:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
   logic        ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done;
   logic        mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [1:0]  word;
   logic [7:0]  flags;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
      .Clk         (clk),
      .Rst         (rst),
      .i_ic_req    (ic_req),
      .i_ic_addr   (ic_addr),
      .o_ic_gnt    (ic_gnt),
      .o_ic_rvalid (ic_rvalid),
      .o_ic_done   (ic_done),
      .i_dc_req    (dc_req),
      .i_dc_we     (dc_we),
      .i_dc_addr   (dc_addr),
      .i_dc_wdata  (dc_wdata),
      .o_dc_gnt    (dc_gnt),
      .o_dc_rvalid (dc_rvalid),
      .o_dc_done   (dc_done),
      .o_rdata     (rdata),
      .o_word      (word),
      .o_mem_req   (mem_req),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_ack   (mem_ack),
      .i_mem_rdata (mem_rdata)
   );

   // D-cache model: write word is a fixed pattern selected by o_word
   assign dc_wdata = 32'hC0DE_0000 | 32'(word);
   // {ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done, mem_req, mem_we}
   assign flags = {ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done, mem_req, mem_we};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ack = 1'b0;
      ic_addr = '0; dc_addr = '0; mem_rdata = '0;
      tick(); tick();

      // ---- reset state
      check("rst_flags", 32'(flags), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_word", 32'(word), 32'h0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      rst = 1'b0;

      // ---- I-only refill, zero-wait, ack held high throughout
      ic_req = 1'b1; ic_addr = 32'h1234; mem_ack = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         mem_rdata = 32'hA000_0000 + i;
         check("i_flags", 32'(flags), (i > 0) ? 32'hC2 : 32'h82);
         check("i_addr", mem_addr, 32'h1230 + 4 * i);
         if (i > 0) begin
            check("i_rdata", rdata, 32'hA000_0000 + i - 1);
            check("i_word", 32'(word), i - 1);
         end
         tick();
      end
      check("i_done_flags", 32'(flags), 32'hE0);
      check("i_done_rdata", rdata, 32'hA000_0003);
      check("i_done_word", 32'(word), 32'h3);
      ic_req = 1'b0;
      tick();
      // spurious acks in DONE and IDLE
      check("spur_idle1_flags", 32'(flags), 32'h0);
      check("spur_idle1_word", 32'(word), 32'h3);
      tick();
      check("spur_idle2_flags", 32'(flags), 32'h0);
      check("spur_idle2_word", 32'(word), 32'h3);

      // ---- both requesting right after reset: D first, then I, then D again
      rst = 1'b1; tick(); rst = 1'b0;
      ic_req = 1'b1; ic_addr = 32'h1234; dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h2008;
      tick();
      for (int i = 0; i < 4; i++) begin
         mem_rdata = 32'hB000_0000 + i;
         check("d_flags", 32'(flags), (i > 0) ? 32'h1A : 32'h12);
         check("d_addr", mem_addr, 32'h2000 + 4 * i);
         tick();
      end
      check("d_done_flags", 32'(flags), 32'h1C);
      check("d_done_rdata", rdata, 32'hB000_0003);
      dc_req = 1'b0;
      tick();
      check("c6_flags", 32'(flags), 32'h0);
      tick();
      // cycle 7: I granted; perturb I address and raise D mid-burst
      ic_addr = 32'h5550; dc_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("i2_flags", 32'(flags), (i > 0) ? 32'hC2 : 32'h82);
         check("i2_addr", mem_addr, 32'h1230 + 4 * i);
         tick();
      end
      check("i2_done_flags", 32'(flags), 32'hE0);
      tick();
      check("c12_flags", 32'(flags), 32'h0);
      tick();
      check("alt_flags", 32'(flags), 32'h12);
      check("alt_addr", mem_addr, 32'h2000);

      // ---- reset after the second ack of D's burst
      tick();
      check("pre_rst_addr", mem_addr, 32'h2004);
      tick();
      check("pre_rst_addr2", mem_addr, 32'h2008);
      rst = 1'b1;
      tick();
      check("mid_rst_flags", 32'(flags), 32'h0);
      check("mid_rst_addr", mem_addr, 32'h0);
      check("mid_rst_rdata", rdata, 32'h0);
      check("mid_rst_word", 32'(word), 32'h0);
      rst = 1'b0;
      tick();
      check("restart_flags", 32'(flags), 32'h12);
      check("restart_addr", mem_addr, 32'h2000);

      // ---- D write-back to 0x80, ack every third cycle
      ic_req = 1'b0; dc_req = 1'b0; mem_ack = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h80;
      tick();
      for (int w = 0; w < 4; w++) begin
         for (int j = 0; j < 3; j++) begin
            mem_ack = (j == 2);
            check("wb_flags", 32'(flags), 32'h13);
            check("wb_addr", mem_addr, 32'h80 + 4 * w);
            check("wb_word", 32'(word), w);
            check("wb_wdata", mem_wdata, 32'hC0DE_0000 + w);
            tick();
         end
      end
      mem_ack = 1'b0;
      check("wb_done_flags", 32'(flags), 32'h14);
      dc_req = 1'b0;
      tick();
      check("wb_idle_flags", 32'(flags), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
